icache_subsystem: RTL and testbench



---
 rtl/icache_subsystem.sv | 155 +++++++++++++++
 tb/tb_icache_subsystem.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/icache_subsystem.sv
`default_nettype none
// ============================================================================
//  Module   : icache_subsystem
//  Purpose  : Read-only, direct-mapped instruction cache between the RV32I
//             fetch stage and main memory. 256-bit lines, 32-bit words.
//             A miss fetches a whole line through a request/status handshake
//             and then serves the word out of the cache.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1    clock, rising edge
//    rst_n       in   1    asynchronous active-low reset
//    cache_read  in   1    fetch request for addr
//    addr        in   32   instruction byte address
//    mmem_status in   1    memory response valid (mmem_out holds the line)
//    mmem_out    in   256  line data, word k in bits [32k+31:32k]
//    mmem_r      out  1    line read request to memory
//    mmem_addr   out  32   line-aligned memory address
//    mmem_wdata  out  32   write data, tied to zero (cache never writes)
//    cache_out   out  32   selected instruction word (0 when not hit)
//    hit         out  1    cache_out valid this cycle
// ============================================================================
module icache_subsystem #(
    parameter int NUM_SETS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cache_read,
    input  logic [31:0]  addr,
    input  logic         mmem_status,
    input  logic [255:0] mmem_out,
    output logic         mmem_r,
    output logic [31:0]  mmem_addr,
    output logic [31:0]  mmem_wdata,
    output logic [31:0]  cache_out,
    output logic         hit
);

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = 27 - INDEX_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_next_state;

    logic [NUM_SETS-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [255:0]        r_data [NUM_SETS];
    logic [26:0]         r_miss_addr;

    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [2:0]          w_word;
    logic                w_lookup_hit;
    logic                w_miss;
    logic                w_fill;
    logic [INDEX_W-1:0]  w_miss_index;
    logic [TAG_W-1:0]    w_miss_tag;
    logic                w_unused;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_word       = addr[4:2];
    assign w_index      = addr[5 +: INDEX_W];
    assign w_tag        = addr[31 -: TAG_W];
    assign w_miss_index = r_miss_addr[INDEX_W-1:0];
    assign w_miss_tag   = r_miss_addr[26 -: TAG_W];
    assign w_unused     = &{1'b0, addr[1:0]};

    // cache_read gates the whole term, so an X/Z address while idle
    // cannot reach the miss latch or the state register.
    assign w_lookup_hit = cache_read && r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_miss       = (r_state == S_IDLE) && cache_read && !w_lookup_hit;
    assign w_fill       = (r_state == S_FETCH) && mmem_status;

    assign mmem_wdata   = 32'd0;

    // ------------------------------------------------------------------
    // State register and control state (async reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_miss) begin
                r_miss_addr <= addr[31:5];
            end
            if (w_fill) begin
                r_valid[w_miss_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    // Reset forces the state to IDLE, so a fill in flight never lands.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_miss_index]  <= w_miss_tag;
            r_data[w_miss_index] <= mmem_out;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cache_read && !w_lookup_hit) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mmem_status) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        hit       = 1'b0;
        cache_out = 32'd0;
        mmem_r    = 1'b0;
        mmem_addr = {addr[31:5], 5'b0};
        case (r_state)
            S_IDLE: begin
                hit = w_lookup_hit;
                if (w_lookup_hit) begin
                    cache_out = r_data[w_index][{w_word, 5'b0} +: 32];
                end
            end
            S_FETCH: begin
                mmem_r    = 1'b1;
                mmem_addr = {r_miss_addr, 5'b0};
            end
            default: begin
                hit = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_subsystem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_subsystem
//  Purpose  : Directed self-checking bench for icache_subsystem, including a
//             combinational main-memory model with programmable wait cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_subsystem;

    logic         clk;
    logic         rst_n;
    logic         cache_read;
    logic [31:0]  addr;
    logic         mmem_status;
    logic [255:0] mmem_out;
    logic         mmem_r;
    logic [31:0]  mmem_addr;
    logic [31:0]  mmem_wdata;
    logic [31:0]  cache_out;
    logic         hit;

    int n_vec = 0;
    int n_err = 0;
    int mem_wait = 0;
    int mem_cnt;

    icache_subsystem #(.NUM_SETS(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cache_read  (cache_read),
        .addr        (addr),
        .mmem_status (mmem_status),
        .mmem_out    (mmem_out),
        .mmem_r      (mmem_r),
        .mmem_addr   (mmem_addr),
        .mmem_wdata  (mmem_wdata),
        .cache_out   (cache_out),
        .hit         (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory: each word holds its own byte address. mem_cnt counts
    // cycles the request has been held, giving mem_wait wait cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mem_cnt <= 0;
        else if (mmem_r) mem_cnt <= mem_cnt + 1;
        else             mem_cnt <= 0;
    end

    always_comb begin
        mmem_status = 1'b0;
        mmem_out    = '0;
        if (mmem_r) begin
            mmem_status = (mem_cnt == mem_wait);
            for (int k = 0; k < 8; k++) begin
                mmem_out[32*k +: 32] = {mmem_addr[31:5], 5'b0} + 32'(4 * k);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cache_read = 1'b0; addr = 'x;
        tick(); tick(); #1;
        n_vec++; if (hit !== 1'b0)        begin n_err++; $display("FAIL reset_hit: got %b want 0", hit); end
        n_vec++; if (mmem_r !== 1'b0)     begin n_err++; $display("FAIL reset_mmem_r: got %b want 0", mmem_r); end
        n_vec++; if (cache_out !== 32'h0) begin n_err++; $display("FAIL reset_cache_out: got %h want 0", cache_out); end
        n_vec++; if (mmem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", mmem_wdata); end
        tick(); rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        tick(); cache_read = 1'b1; addr = 32'h0000_0004; #1;
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL miss0_hit: got %b want 0", hit); end
        n_vec++; if (mmem_addr !== 32'h0) begin n_err++; $display("FAIL miss0_idle_addr: got %h want 0", mmem_addr); end
        tick(); #1;
        n_vec++; if (mmem_r !== 1'b1) begin n_err++; $display("FAIL miss0_fetch_r: got %b want 1", mmem_r); end
        n_vec++; if (mmem_addr !== 32'h0) begin n_err++; $display("FAIL miss0_fetch_addr: got %h want 0", mmem_addr); end
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL miss0_fetch_hit: got %b want 0", hit); end
        tick(); #1;
        n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL miss0_done_hit: got %b want 1", hit); end
        n_vec++; if (cache_out !== 32'h4) begin n_err++; $display("FAIL miss0_done_out: got %h want 00000004", cache_out); end
        n_vec++; if (mmem_r !== 1'b0) begin n_err++; $display("FAIL miss0_done_r: got %b want 0", mmem_r); end
    endtask

    task automatic test_same_line();
        tick(); addr = 32'h0000_001C; #1;
        n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL same_line_hit: got %b want 1", hit); end
        n_vec++; if (cache_out !== 32'h1C) begin n_err++; $display("FAIL same_line_out: got %h want 0000001c", cache_out); end
        n_vec++; if (mmem_r !== 1'b0) begin n_err++; $display("FAIL same_line_r: got %b want 0", mmem_r); end
    endtask

    task automatic test_last_word();
        tick(); addr = 32'h0000_00FF; #1;
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL lastw_miss: got %b want 0", hit); end
        tick(); #1;
        n_vec++; if (mmem_addr !== 32'hE0) begin n_err++; $display("FAIL lastw_addr: got %h want 000000e0", mmem_addr); end
        tick(); #1;
        n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL lastw_hit: got %b want 1", hit); end
        n_vec++; if (cache_out !== 32'hFC) begin n_err++; $display("FAIL lastw_out: got %h want 000000fc", cache_out); end
    endtask

    task automatic test_conflict();
        tick(); addr = 32'h0000_0200; #1;
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL conf_miss: got %b want 0", hit); end
        tick(); tick(); #1;
        n_vec++; if (cache_out !== 32'h200) begin n_err++; $display("FAIL conf_out: got %h want 00000200", cache_out); end
        tick(); addr = 32'h0000_0000; #1;
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL conf_evicted: got %b want 0", hit); end
        tick(); tick(); #1;
        n_vec++; if (cache_out !== 32'h0 || hit !== 1'b1) begin n_err++; $display("FAIL conf_refill: got hit=%b out=%h want hit=1 out=0", hit, cache_out); end
    endtask

    task automatic test_idle_no_read();
        tick(); cache_read = 1'b0; addr = 32'h0000_0004; #1;
        n_vec++; if (hit !== 1'b0 || mmem_r !== 1'b0 || cache_out !== 32'h0) begin n_err++; $display("FAIL noread: got hit=%b r=%b out=%h want 0/0/0", hit, mmem_r, cache_out); end
        tick(); addr = 'x; #1;
        n_vec++; if (hit !== 1'b0 || mmem_r !== 1'b0) begin n_err++; $display("FAIL noread_x: got hit=%b r=%b want 0/0", hit, mmem_r); end
        tick(); cache_read = 1'b1; addr = 32'h0000_0008; #1;
        n_vec++; if (hit !== 1'b1 || cache_out !== 32'h8) begin n_err++; $display("FAIL noread_after: got hit=%b out=%h want 1/00000008", hit, cache_out); end
    endtask

    task automatic test_wait_addr_change();
        mem_wait = 3;
        tick(); addr = 32'h0000_0100; #1;
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL wait_miss: got %b want 0", hit); end
        for (int c = 1; c <= 4; c++) begin
            tick(); addr = 32'h0000_0040; #1;
            n_vec++; if (mmem_r !== 1'b1 || mmem_addr !== 32'h100) begin n_err++; $display("FAIL wait_fetch_c%0d: got r=%b addr=%h want 1/00000100", c, mmem_r, mmem_addr); end
        end
        tick(); #1;
        n_vec++; if (hit !== 1'b0 || mmem_r !== 1'b0 || mmem_addr !== 32'h40) begin n_err++; $display("FAIL wait_new_miss: got hit=%b r=%b addr=%h want 0/0/00000040", hit, mmem_r, mmem_addr); end
        for (int c = 1; c <= 4; c++) begin
            tick(); #1;
            n_vec++; if (mmem_r !== 1'b1 || mmem_addr !== 32'h40) begin n_err++; $display("FAIL wait_fetch2_c%0d: got r=%b addr=%h want 1/00000040", c, mmem_r, mmem_addr); end
        end
        tick(); #1;
        n_vec++; if (hit !== 1'b1 || cache_out !== 32'h40) begin n_err++; $display("FAIL wait_hit40: got hit=%b out=%h want 1/00000040", hit, cache_out); end
        tick(); addr = 32'h0000_0104; #1;
        n_vec++; if (hit !== 1'b1 || cache_out !== 32'h104) begin n_err++; $display("FAIL wait_hit104: got hit=%b out=%h want 1/00000104", hit, cache_out); end
    endtask

    task automatic test_reset_mid_fetch();
        tick(); addr = 32'h0000_0300; #1;
        tick(); #1;
        n_vec++; if (mmem_r !== 1'b1) begin n_err++; $display("FAIL rstfetch_r: got %b want 1", mmem_r); end
        rst_n = 1'b0; #1;
        n_vec++; if (mmem_r !== 1'b0) begin n_err++; $display("FAIL rstfetch_drop: got %b want 0", mmem_r); end
        tick(); rst_n = 1'b1; addr = 32'h0000_0004; #1;
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL rstfetch_cleared: got %b want 0", hit); end
        tick(); #1;
        n_vec++; if (mmem_r !== 1'b1 || mmem_addr !== 32'h0) begin n_err++; $display("FAIL rstfetch_refetch: got r=%b addr=%h want 1/00000000", mmem_r, mmem_addr); end
        for (int c = 0; c < 4; c++) tick();
        #1;
        n_vec++; if (hit !== 1'b1 || cache_out !== 32'h4) begin n_err++; $display("FAIL rstfetch_hit: got hit=%b out=%h want 1/00000004", hit, cache_out); end
        tick(); addr = 32'h0000_0300; mem_wait = 0; #1;
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL rstfetch_nofill: got %b want 0", hit); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_same_line();
        test_last_word();
        test_conflict();
        test_idle_no_read();
        test_wait_addr_change();
        test_reset_mid_fetch();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
